// File: rtl/attr_palette_pkg.sv
// Shared constants for the text-mode attribute palette: default VGA colours,
// index width and the channel truncation helper.
package attr_palette_pkg;

    localparam int IDX_W = 4;
    localparam int PAL_N = 16;

    // Entry 15 is listed first so that VGA_PAL[i] is palette entry i.
    localparam logic [PAL_N-1:0][23:0] VGA_PAL = {
        24'hFFFFFF, 24'hFFFF55, 24'hFF55FF, 24'hFF5555,
        24'h55FFFF, 24'h55FF55, 24'h5555FF, 24'h555555,
        24'hAAAAAA, 24'hAA5500, 24'hAA00AA, 24'hAA0000,
        24'h00AAAA, 24'h00AA00, 24'h0000AA, 24'h000000
    };

    // Keeps the top cw bits of each 8-bit channel, packed right-aligned as {R,G,B}.
    function automatic logic [23:0] pal_trunc(input logic [23:0] c, input int cw);
        logic [23:0] r, g, b;
        r = {16'h0, c[23:16]} >> (8 - cw);
        g = {16'h0, c[15:8]}  >> (8 - cw);
        b = {16'h0, c[7:0]}   >> (8 - cw);
        return (r << (2 * cw)) | (g << cw) | b;
    endfunction

endpackage

// File: rtl/attr_blink_timer.sv
// Counts vsync rising edges and toggles blink_phase every BLINK_FRAMES frames.
module attr_blink_timer #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic blink_phase
);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic          vsync_q;
    logic [FW-1:0] frame_cnt;
    logic          frame_tick;

    // A vsync held high yields exactly one tick.
    assign frame_tick = vsync & ~vsync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (frame_tick) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/attr_palette.sv
// Attribute-to-RGB pixel stage: index select, blink/bright handling, palette lookup.
// ATTR_PALETTE_PROG_EN makes the palette CPU-writable; otherwise it is a constant ROM.
module attr_palette
    import attr_palette_pkg::*;
#(
    parameter int CW           = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              blink_en,
    input  logic              in_valid,
    input  logic [7:0]        attribute,
    input  logic              glyph_bit,
    output logic              out_valid,
    output logic [3*CW-1:0]   out_rgb,
    output logic              blink_phase,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_addr,
    input  logic [3*CW-1:0]   pal_wdata,
    output logic [3*CW-1:0]   pal_rdata
);
    localparam int PW     = 3 * CW;
    localparam int STAGES = 2;

    logic [PAL_N-1:0][PW-1:0] rom;
    logic [PAL_N-1:0][PW-1:0] pal;
    logic [STAGES:1]          vld_pipe;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         bg_idx;
    logic [IDX_W-1:0]         col_idx;
    logic                     hidden;

    always_comb begin
        rom = '0;
        for (int i = 0; i < PAL_N; i++)
            rom[i] = PW'(pal_trunc(VGA_PAL[i], CW));
    end

`ifdef ATTR_PALETTE_PROG_EN
    // Non-blocking update gives read-before-write for both the lookup and pal_rdata.
    always_ff @(posedge clk) begin
        if (!rst_n)
            pal <= rom;
        else if (pal_we)
            pal[pal_addr] <= pal_wdata;
    end
`else
    logic unused_wr;
    assign unused_wr = ^{pal_we, pal_wdata};
    assign pal       = rom;
`endif

    attr_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .blink_phase (blink_phase)
    );

    always_comb begin
        hidden  = blink_en & attribute[7] & blink_phase;
        bg_idx  = blink_en ? {1'b0, attribute[6:4]} : attribute[7:4];
        col_idx = (glyph_bit & ~hidden) ? attribute[3:0] : bg_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            idx_q     <= '0;
            out_rgb   <= '0;
            pal_rdata <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[1], in_valid};
            idx_q     <= col_idx;
            pal_rdata <= pal[pal_addr];
            // Colour holds across invalid cycles.
            if (vld_pipe[1])
                out_rgb <= pal[idx_q];
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_attr_palette.sv
// Self-checking bench for attr_palette: directed scenarios plus randomized traffic
// checked against a frame-count based behavioural model.
module tb_attr_palette;
    localparam int BF = 2;
`ifdef ATTR_PALETTE_PROG_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, vsync, blink_en, in_valid, glyph_bit, pal_we, pal_we4;
    logic [7:0]  attribute;
    logic [3:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic [11:0] pal_wdata4;
    logic        out_valid, blink_phase, out_valid4, blink_phase4;
    logic [23:0] out_rgb, pal_rdata;
    logic [11:0] out_rgb4, pal_rdata4;

    attr_palette #(.CW(8), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .blink_en(blink_en),
        .in_valid(in_valid), .attribute(attribute), .glyph_bit(glyph_bit),
        .out_valid(out_valid), .out_rgb(out_rgb), .blink_phase(blink_phase),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata)
    );

    attr_palette #(.CW(4), .BLINK_FRAMES(BF)) dut4 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .blink_en(blink_en),
        .in_valid(in_valid), .attribute(attribute), .glyph_bit(glyph_bit),
        .out_valid(out_valid4), .out_rgb(out_rgb4), .blink_phase(blink_phase4),
        .pal_we(pal_we4), .pal_addr(pal_addr), .pal_wdata(pal_wdata4), .pal_rdata(pal_rdata4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (CW=8 instance)
    logic [23:0] def_pal [16];
    logic [23:0] pal_m   [16];
    logic        m_vld1;
    logic [3:0]  m_idx1;
    logic        exp_valid, exp_phase, vs_prev;
    logic [23:0] exp_rgb, exp_rdata;
    int          edges;

    function automatic logic [3:0] color_idx(input logic [7:0] a, input logic g,
                                             input logic be, input logic ph);
        logic hid;
        hid = be && a[7] && ph;
        if (g && !hid) return a[3:0];
        if (be) return {1'b0, a[6:4]};
        return a[7:4];
    endfunction

    // Advance the model by one clock using the current inputs, then step the DUT.
    task automatic cycle();
        logic ph;
        ph = ((edges / BF) % 2) == 1;
        if (!rst_n) begin
            pal_m = def_pal;
            m_vld1 = 1'b0; m_idx1 = '0;
            exp_valid = 1'b0; exp_rgb = '0; exp_rdata = '0;
            edges = 0; vs_prev = 1'b0;
        end else begin
            if (m_vld1) exp_rgb = pal_m[m_idx1];
            exp_valid = m_vld1;
            exp_rdata = pal_m[pal_addr];
            m_vld1 = in_valid;
            m_idx1 = color_idx(attribute, glyph_bit, blink_en, ph);
            if (PROG && pal_we) pal_m[pal_addr] = pal_wdata;
            if (vsync && !vs_prev) edges++;
            vs_prev = vsync;
        end
        @(posedge clk); #1;
        exp_phase = ((edges / BF) % 2) == 1;
    endtask

    task automatic idle();
        in_valid = 1'b0; glyph_bit = 1'b0; attribute = '0; vsync = 1'b0;
        blink_en = 1'b0; pal_we = 1'b0; pal_we4 = 1'b0; pal_addr = '0;
        pal_wdata = '0; pal_wdata4 = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        cycle(); cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        checks++; if (out_rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h exp 000000", out_rgb); end
        checks++; if (pal_rdata !== 24'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 000000", pal_rdata); end
        checks++; if (blink_phase !== 1'b0) begin errors++; $display("FAIL reset_phase: got %b exp 0", blink_phase); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        blink_en = 1'b0; in_valid = 1'b1; attribute = 8'h1E; glyph_bit = 1'b1;
        cycle();
        glyph_bit = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b1 || out_rgb !== 24'hFFFF55) begin errors++;
            $display("FAIL basic_fg: got v=%b rgb=%h exp v=1 rgb=FFFF55", out_valid, out_rgb); end
        in_valid = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b1 || out_rgb !== 24'h0000AA) begin errors++;
            $display("FAIL basic_bg: got v=%b rgb=%h exp v=1 rgb=0000AA", out_valid, out_rgb); end
        cycle();
        checks++; if (out_valid !== 1'b0 || out_rgb !== 24'h0000AA) begin errors++;
            $display("FAIL basic_hold: got v=%b rgb=%h exp v=0 rgb=0000AA", out_valid, out_rgb); end
    endtask

    task automatic test_bright();
        blink_en = 1'b0; in_valid = 1'b1; attribute = 8'hC0; glyph_bit = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b1 || out_rgb !== 24'hFF5555) begin errors++;
            $display("FAIL bright_bg: got v=%b rgb=%h exp v=1 rgb=FF5555", out_valid, out_rgb); end
    endtask

    task automatic test_blink();
        logic old_ph, new_ph;
        blink_en = 1'b1; in_valid = 1'b1; attribute = 8'h8F; glyph_bit = 1'b1;
        cycle(); cycle();
        for (int p = 0; p < 6; p++) begin
            old_ph = ((p / BF) % 2) == 1;
            new_ph = (((p + 1) / BF) % 2) == 1;
            vsync = 1'b1;
            cycle();
            vsync = 1'b0;
            cycle();
            // output now carries the pixel sampled in the edge cycle: old phase
            checks++; if (out_rgb !== (old_ph ? 24'h000000 : 24'hFFFFFF)) begin errors++;
                $display("FAIL blink_edge_cycle p=%0d: got %h exp %h", p, out_rgb, old_ph ? 24'h000000 : 24'hFFFFFF); end
            cycle();
            checks++; if (blink_phase !== new_ph || blink_phase !== exp_phase) begin errors++;
                $display("FAIL blink_phase p=%0d: got %b exp %b", p, blink_phase, new_ph); end
            checks++; if (out_rgb !== (new_ph ? 24'h000000 : 24'hFFFFFF) || out_rgb !== exp_rgb) begin errors++;
                $display("FAIL blink_rgb p=%0d: got %h exp %h", p, out_rgb, new_ph ? 24'h000000 : 24'hFFFFFF); end
        end
        in_valid = 1'b0; blink_en = 1'b0;
        cycle(); cycle();
    endtask

    task automatic test_palette_write();
        in_valid = 1'b0; pal_we = 1'b1; pal_addr = 4'd4; pal_wdata = 24'h123456;
        cycle();
        checks++; if (pal_rdata !== 24'hAA0000) begin errors++;
            $display("FAIL rdata_write_cycle: got %h exp AA0000", pal_rdata); end
        pal_we = 1'b0;
        cycle();
        checks++; if (pal_rdata !== (PROG ? 24'h123456 : 24'hAA0000)) begin errors++;
            $display("FAIL rdata_after_write: got %h exp %h", pal_rdata, PROG ? 24'h123456 : 24'hAA0000); end
        in_valid = 1'b1; attribute = 8'h04; glyph_bit = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++; if (out_rgb !== (PROG ? 24'h123456 : 24'hAA0000)) begin errors++;
            $display("FAIL written_pixel: got %h exp %h", out_rgb, PROG ? 24'h123456 : 24'hAA0000); end
    endtask

    task automatic test_collision();
        in_valid = 1'b1; attribute = 8'h04; glyph_bit = 1'b1;
        cycle();
        in_valid = 1'b0; pal_we = 1'b1; pal_addr = 4'd4; pal_wdata = 24'hABCDEF;
        cycle();
        checks++; if (out_rgb !== (PROG ? 24'h123456 : 24'hAA0000) || out_rgb !== exp_rgb) begin errors++;
            $display("FAIL collision_old: got %h exp %h", out_rgb, PROG ? 24'h123456 : 24'hAA0000); end
        pal_we = 1'b0; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++; if (out_rgb !== (PROG ? 24'hABCDEF : 24'hAA0000)) begin errors++;
            $display("FAIL collision_new: got %h exp %h", out_rgb, PROG ? 24'hABCDEF : 24'hAA0000); end
    endtask

    task automatic test_cw4();
        blink_en = 1'b0; in_valid = 1'b1; attribute = 8'h07; glyph_bit = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++; if (out_valid4 !== 1'b1 || out_rgb4 !== 12'hAAA) begin errors++;
            $display("FAIL cw4_rgb: got v=%b rgb=%h exp v=1 rgb=AAA", out_valid4, out_rgb4); end
        pal_we4 = 1'b1; pal_addr = 4'd7; pal_wdata4 = 12'h123;
        cycle();
        pal_we4 = 1'b0; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++; if (out_rgb4 !== (PROG ? 12'h123 : 12'hAAA)) begin errors++;
            $display("FAIL cw4_write: got %h exp %h", out_rgb4, PROG ? 12'h123 : 12'hAAA); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            attribute = 8'($urandom);
            glyph_bit = 1'($urandom);
            if (i % 16 == 0) blink_en = 1'($urandom);
            vsync     = ($urandom_range(0, 4) == 0);
            pal_we    = ($urandom_range(0, 7) == 0);
            pal_addr  = 4'($urandom);
            pal_wdata = 24'($urandom);
            cycle();
            checks++; if (out_valid !== exp_valid || out_rgb !== exp_rgb) begin errors++;
                $display("FAIL rand_out i=%0d: got v=%b rgb=%h exp v=%b rgb=%h", i, out_valid, out_rgb, exp_valid, exp_rgb); end
            checks++; if (pal_rdata !== exp_rdata) begin errors++;
                $display("FAIL rand_rdata i=%0d: got %h exp %h", i, pal_rdata, exp_rdata); end
            checks++; if (blink_phase !== exp_phase) begin errors++;
                $display("FAIL rand_phase i=%0d: got %b exp %b", i, blink_phase, exp_phase); end
        end
        idle();
        cycle(); cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; attribute = 8'($urandom); glyph_bit = 1'($urandom);
            rst_n = (i != 5);
            // a write during reset must not land
            pal_we = (i == 5); pal_addr = 4'd4; pal_wdata = 24'h777777;
            cycle();
            rst_n = 1'b1; pal_we = 1'b0;
            checks++; if (out_valid !== exp_valid || out_rgb !== exp_rgb) begin errors++;
                $display("FAIL midrst_out i=%0d: got v=%b rgb=%h exp v=%b rgb=%h", i, out_valid, out_rgb, exp_valid, exp_rgb); end
            if (i == 5 || i == 6) begin
                checks++; if (out_valid !== 1'b0) begin errors++;
                    $display("FAIL midrst_flush i=%0d: got %b exp 0", i, out_valid); end
            end
        end
        in_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            pal_addr = 4'(a);
            cycle();
            checks++; if (pal_rdata !== def_pal[a]) begin errors++;
                $display("FAIL midrst_pal a=%0d: got %h exp %h", a, pal_rdata, def_pal[a]); end
        end
        in_valid = 1'b1; attribute = 8'h04; glyph_bit = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++; if (out_rgb !== 24'hAA0000) begin errors++;
            $display("FAIL midrst_pixel: got %h exp AA0000", out_rgb); end
    endtask

    initial begin
        def_pal = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
        pal_m = def_pal;
        edges = 0; vs_prev = 1'b0; m_vld1 = 1'b0; m_idx1 = '0;
        exp_valid = 1'b0; exp_rgb = '0; exp_rdata = '0; exp_phase = 1'b0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_bright();
        test_blink();
        test_palette_write();
        test_collision();
        test_cw4();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/attr_palette.md
# attr_palette

Parametrised text-mode attribute-to-RGB pixel stage for the HDMI text console, placed between the glyph-ROM lookup and the TMDS encoder. Each incoming pixel arrives with its 8-bit VGA attribute and one glyph bit. The block selects a foreground or background index, applies frame-counted blinking or bright-background mode, and looks the index up in a 16-entry palette. The palette is CPU-writable and resets to the standard VGA colours. The output is a registered, valid-qualified RGB pixel.

## Interface
Parameters:
- CW, 8: bits per colour channel, legal 4..8.
- BLINK_FRAMES, 16: frames per blink half-period, ≥1.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous, active-low reset.
- vsync  in  1  frame sync level; the rising edge is the frame tick.
- blink_en  in  1  1: attr[7] means blink; 0: attr[7] is background bit 3 (bright background).
- in_valid  in  1  pixel qualifier.
- attribute  in  8  attr[3:0] is the foreground index, attr[6:4] the background index, attr[7] blink or bright.
- glyph_bit  in  1  1 = foreground pixel.
- out_valid  out  1  output qualifier.
- out_rgb  out  3*CW  {R,G,B}.
- blink_phase  out  1  current blink phase, 1 = hidden.
- pal_we  in  1  palette write strobe.
- pal_addr  in  4  palette entry.
- pal_wdata  in  3*CW  new entry value {R,G,B}.
- pal_rdata  out  3*CW  registered read of pal_addr.

## Operation
- Palette reset contents, entries 0..F: 000000, 0000AA, 00AA00, 00AAAA, AA0000, AA00AA, AA5500, AAAAAA, 555555, 5555FF, 55FF55, 55FFFF, FF5555, FF55FF, FFFF55, FFFFFF.
  - Each 8-bit channel is truncated to its top CW bits (value[7:8-CW]).
- Background index: {0, attr[6:4]} when blink_en=1; attr[7:4] when blink_en=0.
- Hidden pixel: blink_en & attr[7] & blink_phase.
- Colour index: the foreground index if glyph_bit & !hidden, otherwise the background index.
- Blink timer:
  - vsync is registered internally for edge detection.
  - Each rising edge increments frame_cnt.
  - When frame_cnt reaches BLINK_FRAMES-1 on an edge, frame_cnt clears to 0 and blink_phase toggles.
  - A vsync held high counts as one edge.
- Palette write: when pal_we=1, pal_addr's entry is updated at the clock edge.
- Palette read: pal_rdata is updated every cycle from pal_addr.
  - Read-before-write: a same-cycle write to the same address returns the old value.

## Timing
- Pipeline latency is 2 cycles.
  - Stage 1 registers the colour index and valid; blink_phase and blink_en are sampled at input time.
  - Stage 2 registers palette[index] into out_rgb and sets out_valid.
- Back-to-back pixels are accepted every cycle; there is no backpressure.
- When in_valid=0, out_valid goes to 0 two cycles later. out_rgb holds its last value.
- Write/lookup collision: a palette write in the same cycle as the stage-2 lookup of that entry outputs the old colour. The new colour is visible from the next cycle.
- Reset values:
  - out_valid=0, out_rgb=0, pal_rdata=0.
  - blink_phase=0, frame_cnt=0, registered vsync=0.
  - Palette back to defaults.
- Reset mid-stream flushes both pipeline stages with no residual valid.
- Reset overrides a simultaneous pal_we.
- blink_phase toggles on the cycle after the vsync edge is detected. Pixels sampled in that cycle use the old phase.

## Configuration
- ATTR_PALETTE_PROG_EN defined: the palette is a writable register file, and pal_we, pal_addr, pal_wdata and pal_rdata behave as above.
- Undefined: the palette is a constant ROM of the default values and pal_we is ignored.
  - pal_rdata still returns the ROM entry for pal_addr with 1-cycle latency.
  - Ports stay present so integration is unchanged.

## Structure
- The shared package holds:
  - the 16×24-bit default VGA palette constant;
  - the palette index width (4);
  - a function that truncates 8-bit channels to CW.
- One sub-module, attr_blink_timer: vsync edge detect, frame counter and blink_phase.
- The palette storage and the 2-stage pipeline live in attr_palette.

## Test plan
- Reset, CW=8, blink_en=0: input attr=0x1E, glyph=1, then glyph=0, each in_valid=1.
  - Outputs 2 cycles later: out_rgb=FFFF55, then 0000AA.
- Bright background, blink_en=0: attr=0xC0, glyph=0 → out_rgb=FF5555.
- Blink, BLINK_FRAMES=2, blink_en=1, attr=0x8F, glyph=1:
  - blink_phase toggles after every 2nd vsync edge.
  - out_rgb alternates FFFFFF / 000000.
- Write palette entry 4 to 123456, then attr=0x04, glyph=1:
  - out_rgb=123456.
  - pal_rdata at addr 4 reads 123456 one cycle after the write, and the old AA0000 when read in the write cycle.
- CW=4: attr=0x07, glyph=1 → out_rgb=AAA. ROM build (no macro): a write to entry 7 is ignored and the output stays AAA.
- Stream 10 valid pixels, assert rst_n=0 for 1 cycle mid-stream:
  - out_valid=0 from the reset cycle until 2 cycles after the next in_valid.
  - Palette is restored to defaults.
